// File: rtl/routine_sel_pkg.sv
// Shared types, defaults and width helper for the routine selector.
// Optional blanking between routines is enabled with ROUTINE_SEL_BLANK_EN.
package routine_sel_pkg;

   typedef enum logic [0:0] {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } routine_sel_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int DEFAULT_BLANK_CYCLES    = 5000000;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : routine_sel_pkg

// File: rtl/select_debounce.sv
// Switch synchroniser, lowest-bit-wins priority encoder and debounce
// counter; publishes the routine index once the request has settled.
module select_debounce
   import routine_sel_pkg::*;
#(
   parameter  int NUM_ROUTINES    = 4,
   parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   localparam int IDX_W           = idx_width(NUM_ROUTINES),
   localparam int CNT_W           = idx_width(DEBOUNCE_CYCLES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_ROUTINES-2:0] select,
   output logic [IDX_W-1:0]        accepted
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (NUM_ROUTINES < 2 || NUM_ROUTINES > 16) begin : g_bad_num_routines
      $error("select_debounce: NUM_ROUTINES must be in 2..16");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("select_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [NUM_ROUTINES-2:0] sync_q1;
   logic [NUM_ROUTINES-2:0] sel_s;
   logic [IDX_W-1:0]        req;
   logic [IDX_W-1:0]        cand;
   logic [CNT_W-1:0]        cnt;

   // Scan from the top down so the lowest set switch is written last and wins.
   always_comb begin
      req = '0;
      for (int k = NUM_ROUTINES - 1; k >= 1; k--) begin
         if (sel_s[k-1]) req = IDX_W'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1  <= '0;
         sel_s    <= '0;
         cand     <= '0;
         cnt      <= '0;
         accepted <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync_q1 <= select;
         sel_s   <= sync_q1;
         if (req != cand) begin
            cand <= req;
            cnt  <= '0;
         end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            accepted <= cand;
         end
      end
   end

endmodule : select_debounce

// File: rtl/routine_selector.sv
// Registered routine selector: debounced switch choice drives one frame to
// the display, with an optional blank gap on change (ROUTINE_SEL_BLANK_EN).
module routine_selector
   import routine_sel_pkg::*;
#(
   parameter  int                 NUM_ROUTINES    = 4,
   parameter  int                 FRAME_W         = 46,
   parameter  int                 DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter  int                 BLANK_CYCLES    = DEFAULT_BLANK_CYCLES,
   parameter  logic [FRAME_W-1:0] BLANK_PATTERN   = '0,
   localparam int                 IDX_W           = idx_width(NUM_ROUTINES)
) (
   input  logic                            Clock,
   input  logic                            Reset_n,
   input  logic [NUM_ROUTINES-2:0]         Select,
   input  logic [NUM_ROUTINES*FRAME_W-1:0] Routines,
   output logic [FRAME_W-1:0]              Frame,
   output logic [IDX_W-1:0]                Active,
   output logic                            Switching
);

   if (BLANK_CYCLES < 1) begin : g_bad_blank
      $error("routine_selector: BLANK_CYCLES must be >= 1");
   end
   if ($bits(BLANK_PATTERN) != FRAME_W) begin : g_bad_pattern
      $error("routine_selector: BLANK_PATTERN width must equal FRAME_W");
   end

   logic [IDX_W-1:0]   accepted;
   logic [FRAME_W-1:0] routine_arr [NUM_ROUTINES];

   for (genvar i = 0; i < NUM_ROUTINES; i++) begin : g_unpack
      assign routine_arr[i] = Routines[i*FRAME_W +: FRAME_W];
   end

   select_debounce #(
      .NUM_ROUTINES   (NUM_ROUTINES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (Clock),
      .rst_n   (Reset_n),
      .select  (Select),
      .accepted(accepted)
   );

`ifdef ROUTINE_SEL_BLANK_EN

   localparam int                 BLANK_W    = idx_width(BLANK_CYCLES);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

   routine_sel_state_t state, state_nxt;
   logic [BLANK_W-1:0] blank_cnt, blank_cnt_nxt;
   logic [FRAME_W-1:0] frame_nxt;
   logic [IDX_W-1:0]   active_nxt;
   logic               switching_nxt;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= SHOW;
         blank_cnt <= '0;
         Frame     <= '0;
         Active    <= '0;
         Switching <= 1'b0;
      end else begin
         state     <= state_nxt;
         blank_cnt <= blank_cnt_nxt;
         Frame     <= frame_nxt;
         Active    <= active_nxt;
         Switching <= switching_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt     = state;
      blank_cnt_nxt = blank_cnt;
      frame_nxt     = Frame;
      active_nxt    = Active;
      switching_nxt = Switching;
      unique case (state)
         SHOW: begin
            if (accepted == Active) begin
               frame_nxt = routine_arr[Active];
            end else begin
               state_nxt     = BLANK;
               blank_cnt_nxt = '0;
               frame_nxt     = BLANK_PATTERN;
               switching_nxt = 1'b1;
            end
         end
         BLANK: begin
            // A selection that moves mid-blank is picked up at exit, not restarted.
            if (blank_cnt == BLANK_LAST) begin
               state_nxt     = SHOW;
               active_nxt    = accepted;
               frame_nxt     = routine_arr[accepted];
               switching_nxt = 1'b0;
            end else begin
               blank_cnt_nxt = blank_cnt + BLANK_W'(1);
               frame_nxt     = BLANK_PATTERN;
            end
         end
         default: state_nxt = SHOW;
      endcase
   end

`else

   // Without blanking the display follows the accepted routine directly.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Frame  <= '0;
         Active <= '0;
      end else begin
         Frame  <= routine_arr[accepted];
         Active <= accepted;
      end
   end

   assign Switching = 1'b0;

`endif

endmodule : routine_selector

// File: tb/tb_routine_selector.sv
// Self-checking bench for routine_selector: vector table, timed corner
// sequences and random switching against a behavioural display model.
module tb_routine_selector;

   localparam int N  = 4;
   localparam int FW = 46;
   localparam int D  = 4;
   localparam int B  = 3;
   localparam logic [FW-1:0] PATTERN = '0;
`ifdef ROUTINE_SEL_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic            Clock;
   logic            Reset_n;
   logic [N-2:0]    Select;
   logic [N*FW-1:0] Routines;
   logic [FW-1:0]   Frame;
   logic [1:0]      Active;
   logic            Switching;

   logic [FW-1:0]   rout [N];

   int errors = 0;
   int checks = 0;

   routine_selector #(
      .NUM_ROUTINES   (N),
      .FRAME_W        (FW),
      .DEBOUNCE_CYCLES(D),
      .BLANK_CYCLES   (B),
      .BLANK_PATTERN  (PATTERN)
   ) dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .Select   (Select),
      .Routines (Routines),
      .Frame    (Frame),
      .Active   (Active),
      .Switching(Switching)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always_comb begin
      Routines = '0;
      for (int i = 0; i < N; i++) Routines[i*FW +: FW] = rout[i];
   end

   // ---------------- behavioural reference ----------------
   logic [N-2:0] sel_seen [$];   // switch values sampled at the last two edges
   int           run_val, run_len;
   int           m_acc, m_active, m_blank_left;
   logic [FW-1:0] m_frame;
   logic          m_sw;

   function automatic int prio(input logic [N-2:0] s);
      for (int k = 1; k < N; k++) if (s[k-1]) return k;
      return 0;
   endfunction

   task automatic model_reset();
      sel_seen = {};
      sel_seen.push_back('0);
      sel_seen.push_back('0);
      run_val      = 0;
      run_len      = 0;
      m_acc        = 0;
      m_active     = 0;
      m_blank_left = 0;
      m_frame      = '0;
      m_sw         = 1'b0;
   endtask

   task automatic model_edge();
      int req, acc_prev;
      req = prio(sel_seen[0]);
      void'(sel_seen.pop_front());
      sel_seen.push_back(Select);
      if (req == run_val) run_len++;
      else begin
         run_val = req;
         run_len = 1;
      end
      acc_prev = m_acc;
      if (run_len >= D + 1) m_acc = run_val;
      if (!BLANK_EN) begin
         m_active = acc_prev;
         m_frame  = rout[acc_prev];
      end else if (m_blank_left == 0) begin
         if (acc_prev == m_active) m_frame = rout[m_active];
         else begin
            m_blank_left = B;
            m_frame      = PATTERN;
            m_sw         = 1'b1;
         end
      end else begin
         m_blank_left--;
         if (m_blank_left == 0) begin
            m_active = acc_prev;
            m_frame  = rout[acc_prev];
            m_sw     = 1'b0;
         end else begin
            m_frame = PATTERN;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      model_edge();
      #1;
      check("model_frame", 64'(Frame), 64'(m_frame));
      check("model_active", 64'(Active), 64'(m_active));
      check("model_switching", 64'(Switching), 64'(m_sw));
   endtask

   typedef struct {
      logic [N-2:0] sel;
      int           hold;
      int           exp_active;
   } vec_t;

   vec_t vecs [8];
   bit   sw_seen;

   initial begin
      rout[0] = 46'h1;
      rout[1] = 46'h1234_5678_9ABC;
      rout[2] = 46'h2BAD_CAFE_F00D;
      rout[3] = 46'h3FFF_0000_FFFF;
      Select  = '0;
      Reset_n = 1'b0;
      model_reset();

      // Reset values and first frame after release
      #2;
      check("reset_frame", 64'(Frame), 64'(0));
      check("reset_active", 64'(Active), 64'(0));
      check("reset_switching", 64'(Switching), 64'(0));
      #21 Reset_n = 1'b1;
      step();
      check("release_frame", 64'(Frame), 64'h1);

      // Vector table: steady-state routine after holding each switch pattern
      vecs[0] = '{3'b000, 14, 0};
      vecs[1] = '{3'b010, 14, 2};
      vecs[2] = '{3'b111, 14, 1};
      vecs[3] = '{3'b100, 14, 3};
      vecs[4] = '{3'b110, 14, 2};
      vecs[5] = '{3'b101, 14, 1};
      vecs[6] = '{3'b011, 14, 1};
      vecs[7] = '{3'b000, 14, 0};
      for (int i = 0; i < 8; i++) begin
         Select = vecs[i].sel;
         repeat (vecs[i].hold) step();
         check($sformatf("vec%0d_active", i), 64'(Active), 64'(vecs[i].exp_active));
         check($sformatf("vec%0d_frame", i), 64'(Frame), 64'(rout[vecs[i].exp_active]));
         check($sformatf("vec%0d_switching", i), 64'(Switching), 64'(0));
      end

      // Switch 0 -> 2 with exact edge timing (first step is edge t)
      Select = 3'b010;
      repeat (7) step();                         // edge t+6
      check("sw2_t6_switching", 64'(Switching), 64'(0));
      check("sw2_t6_frame", 64'(Frame), 64'(rout[0]));
      step();                                    // edge t+7
      check("sw2_t7_switching", 64'(Switching), 64'(BLANK_EN));
      check("sw2_t7_frame", 64'(Frame), BLANK_EN ? 64'(PATTERN) : 64'(rout[2]));
      check("sw2_t7_active", 64'(Active), BLANK_EN ? 64'(0) : 64'(2));
      repeat (2) step();                         // edge t+9
      check("sw2_t9_frame", 64'(Frame), BLANK_EN ? 64'(PATTERN) : 64'(rout[2]));
      step();                                    // edge t+10
      check("sw2_t10_frame", 64'(Frame), 64'(rout[2]));
      check("sw2_t10_active", 64'(Active), 64'(2));
      check("sw2_t10_switching", 64'(Switching), 64'(0));

      // Back to routine 0, then bounce shorter than the debounce window
      Select = 3'b000;
      repeat (14) step();
      sw_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         Select = ((c / 2) % 2 == 1) ? 3'b001 : 3'b000;
         step();
         if (Switching !== 1'b0) sw_seen = 1'b1;
      end
      Select = 3'b000;
      check("bounce_switching_seen", 64'(sw_seen), 64'(0));
      check("bounce_active", 64'(Active), 64'(0));
      repeat (8) step();

      // Request 1, then request 3 one cycle after blank entry
      Select = 3'b001;
      repeat (9) step();                         // edge t+8
      Select = 3'b100;
      repeat (2) step();                         // edge t+10
      check("chg_t10_active", 64'(Active), 64'(1));
      check("chg_t10_frame", 64'(Frame), 64'(rout[1]));
      repeat (9) step();                         // edge t+19
      check("chg_t19_active", 64'(Active), 64'(3));
      check("chg_t19_frame", 64'(Frame), 64'(rout[3]));

      // Reset in the middle of a switch towards routine 2
      Select = 3'b010;
      repeat (9) step();                         // edge t+8
      #3 Reset_n = 1'b0;
      Select = 3'b000;
      #1;
      check("midreset_frame", 64'(Frame), 64'(0));
      check("midreset_active", 64'(Active), 64'(0));
      check("midreset_switching", 64'(Switching), 64'(0));
      model_reset();
      @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
      step();
      check("midreset_release_frame", 64'(Frame), 64'h1);
      check("midreset_release_active", 64'(Active), 64'(0));

      // Random switching and live routine updates against the model
      for (int seg = 0; seg < 40; seg++) begin
         Select = 3'($urandom_range(0, 7));
         for (int c = 0; c < int'($urandom_range(1, 16)); c++) begin
            if ($urandom_range(0, 7) == 0)
               rout[$urandom_range(0, N - 1)] = FW'({$urandom(), $urandom()});
            step();
         end
      end
      Select = 3'b000;
      repeat (14) step();
      check("final_active", 64'(Active), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_routine_selector

// File: doc/routine_selector.md
# routine_selector

Parametrised, registered routine selector: picks one of `NUM_ROUTINES` display frames (LED plus seven-segment words) by priority-encoded slide switches and drives a single registered frame to the board display splitter. It adds switch synchronisation, debounce, and a timed blank interval on every routine change, so the display never shows a torn or bouncing frame. It sits between the routine generators and the display output wiring.

## Interface
- `NUM_ROUTINES`, 4: number of routine frame inputs, legal range 2..16.
- `FRAME_W`, 46: bits per routine frame.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a selection; must be ≥1.
- `BLANK_CYCLES`, 5000000: length of the blank interval on a routine change; must be ≥1.
- `BLANK_PATTERN`, all-zero: frame driven during the blank interval.
- `Clock` input 1: single system clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Select` input `NUM_ROUTINES-1`: raw switch inputs. `Select[k-1]` requests routine k. The lowest k set wins. No bit set requests routine 0.
- `Routines` input `NUM_ROUTINES*FRAME_W`: flattened frames. Routine i occupies bits `[i*FRAME_W +: FRAME_W]`.
- `Frame` output `FRAME_W`: registered displayed frame.
- `Active` output `IDX_W = $clog2(NUM_ROUTINES)`: index currently displayed.
- `Switching` output 1: high while in BLANK.

## Operation
- **Synchroniser**
  - Two-flop synchroniser on `Select`, output `SelS`.
  - `Req` = priority encode of `SelS`, combinational.
- **Debounce**
  - Registers: `Cand` (IDX_W), `Cnt`, `Accepted` (IDX_W).
  - If `Req != Cand`: `Cand <= Req`, `Cnt <= 0`.
  - Otherwise, if `Cnt != DEBOUNCE_CYCLES-1`: `Cnt++`.
  - Otherwise `Accepted <= Cand`. `Cnt` saturates at `DEBOUNCE_CYCLES-1`.
- **FSM (states SHOW, BLANK)**
  - SHOW with `Accepted == Active`: `Frame <= Routines[Active]` every cycle, so live routine updates pass with 1-cycle latency.
  - SHOW with `Accepted != Active`: go to BLANK, `BlankCnt <= 0`, `Frame <= BLANK_PATTERN`, `Switching <= 1`.
  - BLANK: `Frame` holds `BLANK_PATTERN` and `BlankCnt` increments.
  - BLANK with `BlankCnt == BLANK_CYCLES-1`: `Active <= Accepted`, `Frame <= Routines[Accepted]`, `Switching <= 0`, go to SHOW.
  - `Accepted` changing during BLANK does not restart the blank interval. The value of `Accepted` on the exit edge is the one loaded.
  - If that value equals the old `Active`, the routine is restored with no further blank.
- **Reset (asynchronous)**
  - Synchroniser flops, `Cand`, `Cnt`, `Accepted`, `Active`, `BlankCnt` all clear to 0.
  - State = SHOW, `Frame` = 0, `Switching` = 0.
  - Reset mid-BLANK abandons the switch; routine 0 is displayed from the first edge after release.
- Width rule: out-of-range `Accepted` is impossible by construction. `Routines` indexing uses IDX_W bits only.

## Timing
Edge t is the first edge sampling a new stable `Select`; D = `DEBOUNCE_CYCLES`, B = `BLANK_CYCLES`.
- `SelS` valid after edge t+1.
- `Cand` loads at edge t+2.
- `Accepted` updates at edge t+2+D.
- BLANK entered, `Frame` = `BLANK_PATTERN`, at edge t+3+D.
- New routine on `Frame`, and `Active` updated, at edge t+3+D+B.
- A `Select` glitch shorter than D cycles after synchronisation never changes `Accepted`.

## Configuration
- Macro `ROUTINE_SEL_BLANK_EN`.
- Defined: BLANK state, blank interval and `Switching` behave as above.
- Undefined:
  - BLANK state, `BlankCnt` and `BLANK_PATTERN` logic are not compiled.
  - When SHOW sees `Accepted != Active`: `Active <= Accepted` and `Frame <= Routines[Accepted]` on the same edge (edge t+3+D).
  - `Switching` is tied to 0.

## Structure
- Package `routine_sel_pkg`:
  - State enum `routine_sel_state_t` {SHOW, BLANK}.
  - Function computing `IDX_W`.
  - Default constants for `DEBOUNCE_CYCLES` and `BLANK_CYCLES`.
- Sub-module `select_debounce`: synchroniser, priority encoder and debounce counter, parametrised on `NUM_ROUTINES` and `DEBOUNCE_CYCLES`, outputs `Accepted`.
- Top level holds the FSM, blank counter and frame register.

## Test plan
All scenarios use N=4, FRAME_W=46, D=4, B=3, `BLANK_PATTERN`=0, with macro defined unless stated.
- **Reset:** `Reset_n` low mid-cycle, `Routines[0]`=46'h1 -> `Frame`=0, `Active`=0, `Switching`=0 immediately; `Frame`=46'h1 one edge after release.
- **Switch to routine 2:** `Select`=3'b010 held -> `Switching`=1 with `Frame`=0 from edge t+7; `Frame`=`Routines[2]`, `Active`=2 at edge t+10.
- **Priority:** `Select`=3'b111 -> `Active`=1. Then `Select`=3'b100 -> `Active`=3 after 10 edges.
- **Bounce rejection:** `Select` toggles 3'b000/3'b001 every 2 cycles for 40 cycles -> `Active` stays 0, `Switching` never asserts.
- **Change during BLANK:** request routine 1, then routine 3 stable one cycle after BLANK entry -> exits BLANK to 1, then a second BLANK, ending at `Active`=3.
- **Macro undefined:** `Select`=3'b001 -> `Frame`=`Routines[1]` at edge t+7, `Switching` constant 0.
